// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: 640x480@60 VGA timing generator that streams a W x H grey
// image out of memory into the top-left corner of the visible frame.
// Pipeline: counters -> registered address (+ sideband stage 1) -> MEM_LAT-1
// more sideband stages -> registered RGB/sync outputs.
module vga_frame_fetch #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MEM_LAT  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pix_en,
    input  logic [15:0] i_dimensiones,
    input  logic [7:0]  i_pixel,
    output logic [18:0] o_DataAdr_VGA,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank_n,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_frame_start
);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Per-pixel sideband that must travel alongside the memory read.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic img;
    } sb_t;
    localparam sb_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, img: 1'b0};

    logic [9:0]         r_h_cnt, r_v_cnt;
    logic [7:0]         r_w, r_hgt;
    logic [18:0]        r_row_base, r_addr;
    sb_t [MEM_LAT:1]    r_sb_pipe;
    logic               r_hsync, r_vsync, r_blank_n;
    logic [7:0]         r_grey;
    logic               r_frame_start, r_first;

    logic               w_h_last, w_v_last, w_vis, w_img;
    sb_t                w_sb, w_sb_out;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_vis    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_img    = w_vis && (r_h_cnt < {2'b00, r_w}) && (r_v_cnt < {2'b00, r_hgt});
    assign w_sb     = '{hs:  !((r_h_cnt >= H_SYNC_ON) && (r_h_cnt < H_SYNC_OFF)),
                        vs:  !((r_v_cnt >= V_SYNC_ON) && (r_v_cnt < V_SYNC_OFF)),
                        vis: w_vis,
                        img: w_img};
    assign w_sb_out = r_sb_pipe[MEM_LAT];

    // Horizontal/vertical raster counters, advancing one pixel per pix_en.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_pix_en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Image size is sampled only at the frame wrap so a frame never tears.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_w   <= '0;
            r_hgt <= '0;
        end else if (i_pix_en && w_h_last && w_v_last) begin
            r_w   <= i_dimensiones[15:8];
            r_hgt <= i_dimensiones[7:0];
        end
    end

    // Row base accumulates W per image line so no multiplier is needed.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_row_base <= '0;
        end else if (i_pix_en && w_h_last) begin
            if (w_v_last)
                r_row_base <= '0;
            else if (r_v_cnt < {2'b00, r_hgt})
                r_row_base <= r_row_base + {11'd0, r_w};
        end
    end

    // Read address; holds its last value outside the image.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_addr <= '0;
        else if (i_pix_en && w_img)
            r_addr <= r_row_base + {9'd0, r_h_cnt};
    end

    // Delay sync/visibility by the memory latency so they meet their pixel.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 1; i <= MEM_LAT; i++)
                r_sb_pipe[i] <= SB_IDLE;
        end else if (i_pix_en) begin
            r_sb_pipe[1] <= w_sb;
            for (int i = 2; i <= MEM_LAT; i++)
                r_sb_pipe[i] <= r_sb_pipe[i-1];
        end
    end

    // Output register: grey pixel inside the image, black everywhere else.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_grey    <= '0;
        end else if (i_pix_en) begin
            r_hsync   <= w_sb_out.hs;
            r_vsync   <= w_sb_out.vs;
            r_blank_n <= w_sb_out.vis;
            r_grey    <= (w_sb_out.img && w_sb_out.vis) ? i_pixel : 8'd0;
        end
    end

    // Single-clk frame marker at raster wrap, or on the first tick after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_start <= 1'b0;
            r_first       <= 1'b1;
        end else begin
            r_frame_start <= i_pix_en && (r_first || (w_h_last && w_v_last));
            if (i_pix_en)
                r_first <= 1'b0;
        end
    end

    assign o_DataAdr_VGA = r_addr;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_blank_n     = r_blank_n;
    assign o_vga_r       = r_grey;
    assign o_vga_g       = r_grey;
    assign o_vga_b       = r_grey;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch. A reduced-raster instance (24x13,
// visible 16x8) exercises image fetch; a full 800x525 instance checks the
// real line timing.
module tb_vga_frame_fetch;
    localparam int LW = 24;
    localparam int FL = 24 * 13;

    logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
    logic [15:0] dims = 16'h0000;
    logic [7:0]  pixel, pixel_f;

    logic [18:0] s_adr, f_adr;
    logic        s_hs, s_vs, s_bl, s_fs, f_hs, f_vs, f_bl, f_fs;
    logic [7:0]  s_r, s_g, s_b, f_r, f_g, f_b;

    int          vecs = 0, errs = 0, tk = 0, cyc = 0;
    bit          half = 1'b0;
    logic        s_fs_t, s_hs_t;
    logic [7:0]  s_rgb_t;

    typedef struct packed {
        logic [3:0]  f;
        logic [4:0]  h;
        logic [3:0]  v;
        logic [7:0]  rgb;
        logic        bl;
        logic [18:0] adr;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with one tick of latency: the pixel at the registered address.
    assign pixel   = s_adr[7:0];
    assign pixel_f = f_adr[7:0];

    vga_frame_fetch #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(1), .V_BP(2), .MEM_LAT(1)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_pix_en(pix_en), .i_dimensiones(dims),
        .i_pixel(pixel), .o_DataAdr_VGA(s_adr), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_blank_n(s_bl), .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b),
        .o_frame_start(s_fs)
    );

    vga_frame_fetch dut_full (
        .i_clk(clk), .i_reset(rst), .i_pix_en(pix_en), .i_dimensiones(dims),
        .i_pixel(pixel_f), .o_DataAdr_VGA(f_adr), .o_hsync(f_hs), .o_vsync(f_vs),
        .o_blank_n(f_bl), .o_vga_r(f_r), .o_vga_g(f_g), .o_vga_b(f_b),
        .o_frame_start(f_fs)
    );

    // One pix_en tick; in half mode an idle clock follows it.
    task automatic step();
        pix_en = 1'b1;
        @(posedge clk); #1;
        tk++;
        s_fs_t = s_fs; s_hs_t = s_hs; s_rgb_t = s_r;
        if (half) begin
            pix_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Advance until the small instance's outputs show pixel (h,v) of frame fr.
    task automatic adv_to(input int fr, input int h, input int v);
        int tgt;
        tgt = fr * FL + v * LW + h + 2;
        while (tk < tgt) step();
    endtask

    task automatic do_reset(input logic [15:0] d);
        pix_en = 1'b0; dims = d; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; tk = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++; if ({s_hs, s_vs} !== 2'b11) begin errs++; $display("FAIL rst_sync got %b want 11", {s_hs, s_vs}); end
        vecs++; if (s_bl !== 1'b0) begin errs++; $display("FAIL rst_blank got %b want 0", s_bl); end
        vecs++; if ({s_r, s_g, s_b} !== 24'h0) begin errs++; $display("FAIL rst_rgb got %h want 000000", {s_r, s_g, s_b}); end
        vecs++; if (s_adr !== 19'd0) begin errs++; $display("FAIL rst_adr got %0d want 0", s_adr); end
        vecs++; if (s_fs !== 1'b0) begin errs++; $display("FAIL rst_fs got %b want 0", s_fs); end
        vecs++; if ({f_hs, f_vs, f_bl, f_fs} !== 4'b1100) begin errs++; $display("FAIL rst_full got %b want 1100", {f_hs, f_vs, f_bl, f_fs}); end
        vecs++; if ({f_r, f_g, f_b, f_adr} !== 43'd0) begin errs++; $display("FAIL rst_full_data got %h want 0", {f_r, f_g, f_b, f_adr}); end
    endtask

    task automatic test_timing();
        int p, h, v;
        logic ehs, evs, ebl, efs;
        do_reset(16'h0000);
        for (int n = 1; n <= 1700; n++) begin
            step();
            // reduced raster: hsync low h 18..20, vsync low v 10, visible 16x8
            if (n == 1) begin ehs = 1; evs = 1; ebl = 0; end
            else begin
                p = (n - 2) % FL; h = p % LW; v = p / LW;
                ehs = !(h >= 18 && h < 21); evs = (v != 10); ebl = (h < 16 && v < 8);
            end
            efs = (n == 1) || (n % FL == 0);
            vecs++; if ({s_hs, s_vs, s_bl} !== {ehs, evs, ebl}) begin errs++; $display("FAIL tmg_small tick %0d got %b want %b", n, {s_hs, s_vs, s_bl}, {ehs, evs, ebl}); end
            vecs++; if (s_fs !== efs) begin errs++; $display("FAIL tmg_small_fs tick %0d got %b want %b", n, s_fs, efs); end
            // full raster: hsync low h 656..751, visible h<640, no vsync in lines 0..2
            if (n == 1) begin ehs = 1; ebl = 0; end
            else begin
                h = (n - 2) % 800; v = (n - 2) / 800;
                ehs = !(h >= 656 && h < 752); ebl = (h < 640 && v < 480);
            end
            vecs++; if ({f_hs, f_vs, f_bl, f_fs} !== {ehs, 1'b1, ebl, n == 1}) begin errs++; $display("FAIL tmg_full tick %0d got %b want %b", n, {f_hs, f_vs, f_bl, f_fs}, {ehs, 1'b1, ebl, n == 1}); end
        end
    endtask

    task automatic test_image_4x3();
        vec_t tab [13];
        tab = '{'{4'd0, 5'd0,  4'd0, 8'h00, 1'b1, 19'd0},
                '{4'd1, 5'd0,  4'd0, 8'h00, 1'b1, 19'd1},
                '{4'd1, 5'd1,  4'd0, 8'h01, 1'b1, 19'd2},
                '{4'd1, 5'd2,  4'd0, 8'h02, 1'b1, 19'd3},
                '{4'd1, 5'd3,  4'd0, 8'h03, 1'b1, 19'd3},
                '{4'd1, 5'd4,  4'd0, 8'h00, 1'b1, 19'd3},
                '{4'd1, 5'd16, 4'd0, 8'h00, 1'b0, 19'd3},
                '{4'd1, 5'd0,  4'd1, 8'h04, 1'b1, 19'd5},
                '{4'd1, 5'd3,  4'd1, 8'h07, 1'b1, 19'd7},
                '{4'd1, 5'd0,  4'd2, 8'h08, 1'b1, 19'd9},
                '{4'd1, 5'd3,  4'd2, 8'h0B, 1'b1, 19'd11},
                '{4'd1, 5'd0,  4'd3, 8'h00, 1'b1, 19'd11},
                '{4'd1, 5'd0,  4'd8, 8'h00, 1'b0, 19'd11}};
        do_reset(16'h0403);
        foreach (tab[i]) begin
            adv_to(int'(tab[i].f), int'(tab[i].h), int'(tab[i].v));
            vecs++; if ({s_r, s_g, s_b} !== {3{tab[i].rgb}}) begin errs++; $display("FAIL img4x3_rgb f%0d h%0d v%0d got %h want %h", tab[i].f, tab[i].h, tab[i].v, {s_r, s_g, s_b}, {3{tab[i].rgb}}); end
            vecs++; if (s_bl !== tab[i].bl) begin errs++; $display("FAIL img4x3_blank f%0d h%0d v%0d got %b want %b", tab[i].f, tab[i].h, tab[i].v, s_bl, tab[i].bl); end
            vecs++; if (s_adr !== tab[i].adr) begin errs++; $display("FAIL img4x3_adr f%0d h%0d v%0d got %0d want %0d", tab[i].f, tab[i].h, tab[i].v, s_adr, tab[i].adr); end
        end
    endtask

    task automatic test_image_max();
        vec_t tab [6];
        tab = '{'{4'd1, 5'd15, 4'd0, 8'h0F, 1'b1, 19'd15},
                '{4'd1, 5'd0,  4'd1, 8'hFF, 1'b1, 19'd256},
                '{4'd1, 5'd0,  4'd7, 8'hF9, 1'b1, 19'd1786},
                '{4'd1, 5'd15, 4'd7, 8'h08, 1'b1, 19'd1800},
                '{4'd1, 5'd16, 4'd7, 8'h00, 1'b0, 19'd1800},
                '{4'd1, 5'd0,  4'd8, 8'h00, 1'b0, 19'd1800}};
        do_reset(16'hFFFF);
        foreach (tab[i]) begin
            adv_to(int'(tab[i].f), int'(tab[i].h), int'(tab[i].v));
            vecs++; if ({s_r, s_g, s_b} !== {3{tab[i].rgb}}) begin errs++; $display("FAIL imgmax_rgb h%0d v%0d got %h want %h", tab[i].h, tab[i].v, {s_r, s_g, s_b}, {3{tab[i].rgb}}); end
            vecs++; if (s_bl !== tab[i].bl) begin errs++; $display("FAIL imgmax_blank h%0d v%0d got %b want %b", tab[i].h, tab[i].v, s_bl, tab[i].bl); end
            vecs++; if (s_adr !== tab[i].adr) begin errs++; $display("FAIL imgmax_adr h%0d v%0d got %0d want %0d", tab[i].h, tab[i].v, s_adr, tab[i].adr); end
        end
    endtask

    task automatic test_dim_change();
        vec_t tab [10];
        tab = '{'{4'd1, 5'd3, 4'd1, 8'h07, 1'b1, 19'd7},
                '{4'd1, 5'd3, 4'd2, 8'h0B, 1'b1, 19'd11},
                '{4'd1, 5'd0, 4'd3, 8'h00, 1'b1, 19'd11},
                '{4'd2, 5'd0, 4'd0, 8'h00, 1'b1, 19'd1},
                '{4'd2, 5'd1, 4'd0, 8'h01, 1'b1, 19'd1},
                '{4'd2, 5'd2, 4'd0, 8'h00, 1'b1, 19'd1},
                '{4'd2, 5'd0, 4'd1, 8'h02, 1'b1, 19'd3},
                '{4'd2, 5'd1, 4'd1, 8'h03, 1'b1, 19'd3},
                '{4'd2, 5'd2, 4'd1, 8'h00, 1'b1, 19'd3},
                '{4'd2, 5'd0, 4'd2, 8'h00, 1'b1, 19'd3}};
        do_reset(16'h0403);
        adv_to(1, 0, 1);
        dims = 16'h0202;
        foreach (tab[i]) begin
            adv_to(int'(tab[i].f), int'(tab[i].h), int'(tab[i].v));
            vecs++; if ({s_r, s_g, s_b} !== {3{tab[i].rgb}}) begin errs++; $display("FAIL dimchg_rgb f%0d h%0d v%0d got %h want %h", tab[i].f, tab[i].h, tab[i].v, {s_r, s_g, s_b}, {3{tab[i].rgb}}); end
            vecs++; if (s_adr !== tab[i].adr) begin errs++; $display("FAIL dimchg_adr f%0d h%0d v%0d got %0d want %0d", tab[i].f, tab[i].h, tab[i].v, s_adr, tab[i].adr); end
        end
    endtask

    task automatic test_pix_en_half();
        int c0;
        do_reset(16'h0403);
        c0 = cyc;
        half = 1'b1;
        adv_to(0, 22, 12);
        vecs++; if (s_fs_t !== 1'b1) begin errs++; $display("FAIL half_fs_tick got %b want 1", s_fs_t); end
        vecs++; if (s_fs !== 1'b0) begin errs++; $display("FAIL half_fs_idle got %b want 0", s_fs); end
        adv_to(1, 1, 0);
        vecs++; if (s_rgb_t !== 8'h01) begin errs++; $display("FAIL half_rgb_tick got %h want 01", s_rgb_t); end
        vecs++; if (s_r !== 8'h01) begin errs++; $display("FAIL half_rgb_idle got %h want 01", s_r); end
        vecs++; if (cyc - c0 !== 2 * 315) begin errs++; $display("FAIL half_clk_count got %0d want %0d", cyc - c0, 2 * 315); end
        adv_to(1, 18, 0);
        vecs++; if ({s_hs_t, s_hs} !== 2'b00) begin errs++; $display("FAIL half_hsync got %b want 00", {s_hs_t, s_hs}); end
        half = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(16'h0403);
        adv_to(1, 2, 1);
        vecs++; if (s_r !== 8'h06) begin errs++; $display("FAIL mid_pre_rgb got %h want 06", s_r); end
        #3; rst = 1'b1; #1;
        vecs++; if ({s_hs, s_vs, s_bl, s_fs} !== 4'b1100) begin errs++; $display("FAIL mid_async_ctl got %b want 1100", {s_hs, s_vs, s_bl, s_fs}); end
        vecs++; if ({s_r, s_adr} !== 27'd0) begin errs++; $display("FAIL mid_async_data got %h want 0", {s_r, s_adr}); end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; tk = 0;
        step();
        vecs++; if ({s_fs, s_bl} !== 2'b10) begin errs++; $display("FAIL mid_restart_fs got %b want 10", {s_fs, s_bl}); end
        adv_to(0, 0, 0);
        vecs++; if ({s_bl, s_r} !== 9'h100) begin errs++; $display("FAIL mid_first_pix got %h want 100", {s_bl, s_r}); end
        adv_to(0, 18, 0);
        vecs++; if (s_hs !== 1'b0) begin errs++; $display("FAIL mid_hsync_restart got %b want 0", s_hs); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_image_4x3();
        test_image_max();
        test_dim_change();
        test_pix_en_half();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
